// File: rtl/csr_pkg.sv
// Shared CSR addresses, Zicsr operation encodings and the read-modify-write helper.
package csr_pkg;

  typedef enum logic [1:0] {
    CSR_OP_NONE = 2'b00,
    CSR_OP_RW   = 2'b01,
    CSR_OP_RS   = 2'b10,
    CSR_OP_RC   = 2'b11
  } csr_op_e;

  localparam logic [11:0] CSR_CYCLE     = 12'hC00;
  localparam logic [11:0] CSR_INSTRET   = 12'hC02;
  localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
  localparam logic [11:0] CSR_INSTRETH  = 12'hC82;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
  localparam logic [11:0] CSR_TOHOST    = 12'h51E;

  function automatic logic [31:0] csr_apply(input csr_op_e op, input logic [31:0] old,
                                            input logic [31:0] src);
    logic [31:0] res;
    case (op)
      CSR_OP_RW: res = src;
      CSR_OP_RS: res = old | src;
      CSR_OP_RC: res = old & ~src;
      default:   res = old;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/csr_counter.sv
// Free-running W-bit counter whose 32-bit halves can be overwritten; a write
// suppresses that cycle's increment and never carries into the other half.
module csr_counter #(
  parameter int unsigned W = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc,
  input  logic          wr_lo,
  input  logic          wr_hi,
  input  logic [31:0]   wdata,
  output logic [W-1:0]  value
);

  always_ff @(posedge clk) begin
    if (rst) begin
      value <= '0;
    end else if (wr_lo || wr_hi) begin
      if (wr_lo) value[31:0]   <= wdata;
      if (wr_hi) value[W-1:32] <= wdata[W-33:0];
    end else if (inc) begin
      value <= value + W'(1);
    end
  end

endmodule

// File: rtl/csr_file.sv
// Zicsr register file: general CSR bank, cycle/instret counters and tohost.
module csr_file
  import csr_pkg::*;
#(
  parameter int unsigned NUM_USER  = 4,
  parameter logic [11:0] USER_BASE = CSR_TOHOST,
  parameter int unsigned CNT_W     = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        csr_valid,
  input  logic [11:0] csr_addr,
  input  logic [1:0]  csr_op,
  input  logic [31:0] csr_src,
  input  logic        csr_src_zero,
  input  logic        retire,
  output logic [31:0] csr_rdata,
  output logic        csr_illegal,
  output logic [31:0] tohost
);

  csr_op_e          op;
  logic [11:0]      user_off;
  logic             user_hit;
  logic [31:0]      user_q [NUM_USER];
  logic [CNT_W-1:0] cycle_val;
  logic [CNT_W-1:0] instret_val;
  logic [31:0]      old;
  logic [31:0]      wdata;
  logic             mapped;
  logic             ro;
  logic             probe;
  logic             active;
  logic             we;

  assign op       = csr_op_e'(csr_op);
  assign user_off = csr_addr - USER_BASE;
  assign user_hit = user_off < 12'(NUM_USER);

  always_comb begin
    old    = '0;
    mapped = 1'b0;
    ro     = 1'b0;
    if (user_hit) begin
      mapped = 1'b1;
      for (int unsigned i = 0; i < NUM_USER; i++) begin
        if (user_off == 12'(i)) old = user_q[i];
      end
    end else begin
      case (csr_addr)
        CSR_CYCLE:     begin old = cycle_val[31:0];                mapped = 1'b1; ro = 1'b1; end
        CSR_CYCLEH:    begin old = 32'(cycle_val[CNT_W-1:32]);     mapped = 1'b1; ro = 1'b1; end
        CSR_INSTRET:   begin old = instret_val[31:0];              mapped = 1'b1; ro = 1'b1; end
        CSR_INSTRETH:  begin old = 32'(instret_val[CNT_W-1:32]);   mapped = 1'b1; ro = 1'b1; end
        CSR_MCYCLE:    begin old = cycle_val[31:0];                mapped = 1'b1; end
        CSR_MCYCLEH:   begin old = 32'(cycle_val[CNT_W-1:32]);     mapped = 1'b1; end
        CSR_MINSTRET:  begin old = instret_val[31:0];              mapped = 1'b1; end
        CSR_MINSTRETH: begin old = 32'(instret_val[CNT_W-1:32]);   mapped = 1'b1; end
        default: ;
      endcase
    end
  end

  // RS/RC with a zero source is a pure read, so it is legal even on read-only counters.
  assign probe       = (op == CSR_OP_RS || op == CSR_OP_RC) && csr_src_zero;
  assign active      = csr_valid && (op != CSR_OP_NONE);
  assign csr_illegal = active && (!mapped || (ro && !probe));
  assign we          = active && mapped && !ro && !probe;
  assign csr_rdata   = csr_valid ? old : '0;
  assign wdata       = csr_apply(op, old, csr_src);

  for (genvar g = 0; g < NUM_USER; g++) begin : g_user
    logic [31:0] q;
    always_ff @(posedge clk) begin
      if (rst) begin
        q <= '0;
      end else if (we && user_hit && user_off == 12'(g)) begin
        q <= wdata;
      end
    end
    assign user_q[g] = q;
  end

  assign tohost = user_q[0];

  csr_counter #(.W(CNT_W)) u_cycle (
    .clk   (clk),
    .rst   (rst),
    .inc   (1'b1),
    .wr_lo (we && csr_addr == CSR_MCYCLE),
    .wr_hi (we && csr_addr == CSR_MCYCLEH),
    .wdata (wdata),
    .value (cycle_val)
  );

  csr_counter #(.W(CNT_W)) u_instret (
    .clk   (clk),
    .rst   (rst),
    .inc   (retire),
    .wr_lo (we && csr_addr == CSR_MINSTRET),
    .wr_hi (we && csr_addr == CSR_MINSTRETH),
    .wdata (wdata),
    .value (instret_val)
  );

endmodule

// File: tb/tb_csr_file.sv
// Directed and randomized checks of csr_file against a behavioural CSR model.
module tb_csr_file;

  localparam int unsigned NU = 4;
  localparam logic [11:0] UB = 12'h51E;
  localparam int unsigned CW = 64;
  localparam longint unsigned MASK = (CW >= 64) ? 64'hFFFF_FFFF_FFFF_FFFF
                                                : ((64'd1 << CW) - 64'd1);

  logic        clk = 1'b0;
  logic        rst;
  logic        csr_valid;
  logic [11:0] csr_addr;
  logic [1:0]  csr_op;
  logic [31:0] csr_src;
  logic        csr_src_zero;
  logic        retire;
  logic [31:0] csr_rdata;
  logic        csr_illegal;
  logic [31:0] tohost;

  always #5 clk = ~clk;

  csr_file #(.NUM_USER(NU), .USER_BASE(UB), .CNT_W(CW)) dut (
    .clk          (clk),
    .rst          (rst),
    .csr_valid    (csr_valid),
    .csr_addr     (csr_addr),
    .csr_op       (csr_op),
    .csr_src      (csr_src),
    .csr_src_zero (csr_src_zero),
    .retire       (retire),
    .csr_rdata    (csr_rdata),
    .csr_illegal  (csr_illegal),
    .tohost       (tohost)
  );

  int unsigned     user_m [NU];
  longint unsigned cyc_m = 0;
  longint unsigned ir_m  = 0;
  int              tests = 0;
  int              fails = 0;
  logic [31:0]     obs_rd;
  logic            obs_ill;
  logic [31:0]     obs_th;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  function automatic void model_read(input logic [11:0] a, output logic [31:0] rd,
                                     output bit mapped, output bit ro);
    longint unsigned c;
    rd = 0; mapped = 0; ro = 0;
    if (a >= UB && a < UB + NU) begin
      rd = user_m[a - UB];
      mapped = 1;
    end else if (a == 12'hC00 || a == 12'hC80 || a == 12'hC02 || a == 12'hC82 ||
                 a == 12'hB00 || a == 12'hB80 || a == 12'hB02 || a == 12'hB82) begin
      mapped = 1;
      ro = (a[11:8] == 4'hC);
      c  = a[1] ? ir_m : cyc_m;
      rd = a[7] ? c[63:32] : c[31:0];
    end
  endfunction

  task automatic step(input bit r, input bit v, input logic [11:0] a, input logic [1:0] op,
                      input logic [31:0] src, input bit z, input bit ret);
    logic [31:0] old, nv, exp_rd;
    bit mapped, ro, probe, active, exp_ill, we;
    longint unsigned cyc_n, ir_n;
    rst = r; csr_valid = v; csr_addr = a; csr_op = op;
    csr_src = src; csr_src_zero = z; retire = ret;
    model_read(a, old, mapped, ro);
    probe   = (op == 2'b10 || op == 2'b11) && z;
    active  = v && op != 2'b00;
    exp_ill = active && (!mapped || (ro && !probe));
    we      = active && mapped && !ro && !probe;
    exp_rd  = v ? old : 32'h0;
    case (op)
      2'b01:   nv = src;
      2'b10:   nv = old | src;
      2'b11:   nv = old & ~src;
      default: nv = old;
    endcase
    @(negedge clk);
    obs_rd = csr_rdata; obs_ill = csr_illegal; obs_th = tohost;
    check("rdata", obs_rd, exp_rd);
    check("illegal", {31'b0, obs_ill}, {31'b0, exp_ill});
    check("tohost", obs_th, user_m[0]);
    @(posedge clk);
    if (r) begin
      foreach (user_m[i]) user_m[i] = 0;
      cyc_m = 0; ir_m = 0;
    end else begin
      cyc_n = (cyc_m + 1) & MASK;
      ir_n  = (ir_m + (ret ? 1 : 0)) & MASK;
      if (we) begin
        if (a >= UB && a < UB + NU) user_m[a - UB] = nv;
        else if (a == 12'hB00) cyc_n = {cyc_m[63:32], nv};
        else if (a == 12'hB80) cyc_n = {nv, cyc_m[31:0]} & MASK;
        else if (a == 12'hB02) ir_n  = {ir_m[63:32], nv};
        else if (a == 12'hB82) ir_n  = {nv, ir_m[31:0]} & MASK;
      end
      cyc_m = cyc_n; ir_m = ir_n;
    end
    #1;
  endtask

  initial begin
    logic [11:0] ra;
    logic [31:0] rs;
    bit          rz;
    rst = 1'b1; csr_valid = 1'b0; csr_addr = '0; csr_op = '0;
    csr_src = '0; csr_src_zero = 1'b0; retire = 1'b0;
    foreach (user_m[i]) user_m[i] = 0;
    repeat (2) @(posedge clk);
    #1;

    // reset state, then cycle count at the 10th cycle after release
    step(0, 1, UB, 2'b10, 32'h0, 1, 0);
    check("reset_rd", obs_rd, 32'h0);
    check("reset_ill", {31'b0, obs_ill}, 32'h0);
    check("reset_tohost", obs_th, 32'h0);
    repeat (9) step(0, 0, 12'h0, 2'b00, 32'h0, 0, 0);
    step(0, 1, 12'hC00, 2'b10, 32'h0, 1, 0);
    check("cycle10", obs_rd, 32'd10);

    repeat (3) step(0, 0, 12'h0, 2'b00, 32'h0, 0, 1);
    step(0, 1, 12'hC02, 2'b11, 32'h0, 1, 0);
    check("instret3", obs_rd, 32'd3);

    // tohost read-modify-write
    step(0, 1, UB, 2'b01, 32'hDEADBEEF, 0, 0);
    step(0, 1, UB, 2'b10, 32'h0000000F, 0, 0);
    check("rs_old", obs_rd, 32'hDEADBEEF);
    check("rw_tohost", obs_th, 32'hDEADBEEF);
    step(0, 1, UB, 2'b11, 32'hF0000000, 0, 0);
    check("rs_tohost", obs_th, 32'hDEADBEEF);
    step(0, 0, 12'h0, 2'b00, 32'h0, 0, 0);
    check("rc_tohost", obs_th, 32'h0EADBEEF);

    // zero-source RC must not write; unmapped access is illegal
    step(0, 1, UB + 12'd1, 2'b01, 32'h12345678, 0, 0);
    step(0, 1, UB + 12'd1, 2'b11, 32'hFFFFFFFF, 1, 0);
    step(0, 1, UB + 12'd1, 2'b10, 32'h0, 1, 0);
    check("rc_zero_keep", obs_rd, 32'h12345678);
    step(0, 1, 12'h7FF, 2'b01, 32'h55555555, 0, 0);
    check("unmapped_ill", {31'b0, obs_ill}, 32'h1);
    check("unmapped_rd", obs_rd, 32'h0);

    // read-only write attempt, then counter wrap
    step(0, 1, 12'hC00, 2'b01, 32'h0, 0, 0);
    check("ro_ill", {31'b0, obs_ill}, 32'h1);
    step(0, 1, 12'hC00, 2'b10, 32'h0, 1, 0);
    step(0, 1, 12'hB80, 2'b01, 32'hFFFFFFFF, 0, 0);
    step(0, 1, 12'hB00, 2'b01, 32'hFFFFFFFE, 0, 0);
    step(0, 1, 12'hC80, 2'b10, 32'h0, 1, 0);
    check("wrap_pre_hi", obs_rd, 32'hFFFFFFFF);
    step(0, 0, 12'h0, 2'b00, 32'h0, 0, 0);
    step(0, 1, 12'hC00, 2'b10, 32'h0, 1, 0);
    check("wrap_lo", obs_rd, 32'h0);
    step(0, 1, 12'hC80, 2'b10, 32'h0, 1, 0);
    check("wrap_hi", obs_rd, 32'h0);

    // retire collides with a minstret write
    step(0, 1, 12'hB02, 2'b01, 32'd5, 0, 1);
    step(0, 1, 12'hC02, 2'b10, 32'h0, 1, 0);
    check("collision", obs_rd, 32'd5);

    // reset discards a concurrent write
    step(0, 1, UB, 2'b01, 32'h13579BDF, 0, 0);
    step(1, 1, UB, 2'b01, 32'hAAAA5555, 0, 0);
    step(0, 1, UB, 2'b10, 32'h0, 1, 0);
    check("rst_discard", obs_rd, 32'h0);
    check("rst_tohost", obs_th, 32'h0);

    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 9))
        0: ra = UB + 12'($urandom_range(0, NU - 1));
        1: ra = 12'hB00;
        2: ra = 12'hB80;
        3: ra = 12'hB02;
        4: ra = 12'hB82;
        5: ra = 12'hC00;
        6: ra = 12'hC80;
        7: ra = 12'hC02;
        8: ra = 12'hC82;
        default: ra = 12'($urandom);
      endcase
      rs = $urandom;
      if ($urandom_range(0, 3) == 0) begin
        rz = 1;
        if ($urandom_range(0, 1) == 0) rs = 32'h0;
      end else begin
        rz = (rs == 32'h0);
      end
      step($urandom_range(0, 63) == 0, $urandom_range(0, 7) != 0, ra,
           2'($urandom_range(0, 3)), rs, rz, $urandom_range(0, 1) == 1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
